// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, iotrap/csr_op encodings, mstatus bit positions, FSM states.
package csr_trap_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;

   localparam logic [1:0] IOTRAP_NONE = 2'b00;
   localparam logic [1:0] IOTRAP_RSVD = 2'b01;
   localparam logic [1:0] IOTRAP_IN   = 2'b10;
   localparam logic [1:0] IOTRAP_OUT  = 2'b11;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Bundle between the trap control unit / EXU / fetch (master) and the CSR trap unit (slave).
// With CSR_COUNTERS_EN defined, carries the instr_retire strobe for minstret.
interface csr_trap_unit_if #(
   parameter int XLEN = 64
);
   logic            csrUpdata;
   logic [1:0]      iotrap;
   logic [XLEN-1:0] mcause_n;
   logic [XLEN-1:0] mepc_n;
   logic            mstatus_n;
   logic            csr_we;
   logic [1:0]      csr_op;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            gIntEn;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect_ready;
   logic            busy;
`ifdef CSR_COUNTERS_EN
   logic            instr_retire;
`endif

   modport slave (
      input  csrUpdata, iotrap, mcause_n, mepc_n, mstatus_n,
      input  csr_we, csr_op, csr_addr, csr_wdata, redirect_ready,
`ifdef CSR_COUNTERS_EN
      input  instr_retire,
`endif
      output csr_rdata, gIntEn, redirect_valid, redirect_pc, busy
   );

   modport master (
      output csrUpdata, iotrap, mcause_n, mepc_n, mstatus_n,
      output csr_we, csr_op, csr_addr, csr_wdata, redirect_ready,
`ifdef CSR_COUNTERS_EN
      output instr_retire,
`endif
      input  csr_rdata, gIntEn, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/csr_trap_unit_alu.sv
// Combinational new-value computation for csrrw/csrrs/csrrc.
// Shared by the machine CSRs and the optional counters.
module csr_trap_unit_alu
   import csr_trap_unit_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  csr_op_e         op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] new_val
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      new_val = old_val;
      case (op)
         CSR_OP_RW: new_val = wdata;
         CSR_OP_RS: new_val = old_val | wdata;
         CSR_OP_RC: new_val = old_val & ~wdata;
         default:   new_val = old_val;
      endcase
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap entry/mret sequencer with a held fetch redirect.
// Define CSR_COUNTERS_EN to add mcycle/minstret and the instr_retire input.
module csr_trap_unit
   import csr_trap_unit_pkg::*;
#(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] MTVEC_RST = 64'h8000_0000
) (
   input logic            clk,
   input logic            rst,
   csr_trap_unit_if.slave bus
);

   state_e          state_q, state_d;
   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;
`endif

   logic [XLEN-1:0] mstatus_rd;
   logic [XLEN-1:0] csr_old;
   logic [XLEN-1:0] csr_new;
   logic            trap_go;
   logic            csr_wr;

   // mstatus.MIE is an informational copy upstream; it drives nothing here.
   logic unused_sink;
   assign unused_sink = &{1'b0, bus.mstatus_n};

   always_comb begin
      mstatus_rd                                = '0;
      mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
      mstatus_rd[MSTATUS_MIE]                   = mie_q;
   end

   always_comb begin
      csr_old = '0;
      case (bus.csr_addr)
         CSR_MSTATUS:  csr_old = mstatus_rd;
         CSR_MTVEC:    csr_old = mtvec_q;
         CSR_MSCRATCH: csr_old = mscratch_q;
         CSR_MEPC:     csr_old = mepc_q;
         CSR_MCAUSE:   csr_old = mcause_q;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:   csr_old = mcycle_q;
         CSR_MINSTRET: csr_old = minstret_q;
`endif
         default:      csr_old = '0;
      endcase
   end

   csr_trap_unit_alu #(.XLEN(XLEN)) u_alu (
      .op      (csr_op_e'(bus.csr_op)),
      .old_val (csr_old),
      .wdata   (bus.csr_wdata),
      .new_val (csr_new)
   );

   // A trap commit in the same cycle takes priority and drops the CSR write.
   assign trap_go = (state_q == ST_IDLE) && bus.csrUpdata &&
                    ((bus.iotrap == IOTRAP_IN) || (bus.iotrap == IOTRAP_OUT));
   assign csr_wr  = (state_q == ST_IDLE) && bus.csr_we &&
                    (bus.csr_op != CSR_OP_NONE) && !trap_go;

   always_comb begin
      state_d          = state_q;
      mie_d            = mie_q;
      mpie_d           = mpie_q;
      mtvec_d          = mtvec_q;
      mscratch_d       = mscratch_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (trap_go) begin
               if (bus.iotrap == IOTRAP_IN) begin
                  mepc_d        = {bus.mepc_n[XLEN-1:2], 2'b00};
                  mcause_d      = bus.mcause_n;
                  mpie_d        = mie_q;
                  mie_d         = 1'b0;
                  redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
               end else begin
                  mie_d         = mpie_q;
                  mpie_d        = 1'b1;
                  redirect_pc_d = mepc_q;
               end
               redirect_valid_d = 1'b1;
               state_d          = ST_REDIRECT;
            end else if (csr_wr) begin
               case (bus.csr_addr)
                  CSR_MSTATUS: begin
                     mie_d  = csr_new[MSTATUS_MIE];
                     mpie_d = csr_new[MSTATUS_MPIE];
                  end
                  CSR_MTVEC:    mtvec_d    = {csr_new[XLEN-1:2], 2'b00};
                  CSR_MSCRATCH: mscratch_d = csr_new;
                  CSR_MEPC:     mepc_d     = {csr_new[XLEN-1:2], 2'b00};
                  CSR_MCAUSE:   mcause_d   = csr_new;
                  default: ;
               endcase
            end
         end
         ST_REDIRECT: begin
            if (bus.redirect_ready) begin
               redirect_valid_d = 1'b0;
               state_d          = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef CSR_COUNTERS_EN
   always_comb begin
      mcycle_d   = mcycle_q + XLEN'(1);
      minstret_d = minstret_q + XLEN'(bus.instr_retire);
      if (csr_wr && (bus.csr_addr == CSR_MCYCLE))   mcycle_d   = csr_new;
      if (csr_wr && (bus.csr_addr == CSR_MINSTRET)) minstret_d = csr_new;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         mie_q            <= 1'b1;
         mpie_q           <= 1'b0;
         mtvec_q          <= MTVEC_RST;
         mscratch_q       <= '0;
         mepc_q           <= '0;
         mcause_q         <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         mie_q            <= mie_d;
         mpie_q           <= mpie_d;
         mtvec_q          <= mtvec_d;
         mscratch_q       <= mscratch_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign bus.csr_rdata      = csr_old;
   assign bus.gIntEn         = mie_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.busy           = (state_q == ST_REDIRECT);

endmodule
